lcd_text_buffer: RTL
====================

# lcd_text_buffer

Character frame buffer and refresh sequencer that sits directly upstream of the 16x2 LCD controller (`test_lcd1602`-style driver). Game/UI logic writes characters into a 2x16 shadow store at any time. When contents change or a refresh is requested, the block streams a full frame to the LCD controller over a valid/ready byte stream. Each row is sent as one DDRAM-address command followed by 16 character bytes.

## Interface
Parameters:
- `COLS`, 16, characters per row
- `ROWS`, 2, rows (1 or 2 supported)
- `BLANK_CHAR`, 8'h20, fill value on reset/clear

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `wr_en`  in  1  write strobe, one character per cycle
- `wr_addr`  in  5  row*COLS + col; addresses >= ROWS*COLS ignored
- `wr_data`  in  8  character code
- `clear`  in  1  one-cycle pulse: fill store with `BLANK_CHAR`
- `refresh_req`  in  1  force a full frame even if not dirty
- `out_valid`  out  1  stream item present
- `out_ready`  in  1  LCD controller accepts item
- `out_is_cmd`  out  1  1 = command byte (rs=0), 0 = character (rs=1)
- `out_data`  out  8  command or character byte
- `busy`  out  1  frame in progress (state != IDLE)
- `frame_done`  out  1  one-cycle pulse after last item of a frame accepted

## Operation
- Reset values: store = `BLANK_CHAR` everywhere; dirty = 1 (first frame follows reset); `out_valid`=0, `out_is_cmd`=0, `out_data`=0, `busy`=0, `frame_done`=0; state IDLE.
- Writes and `clear` take effect at the clock edge, in any state. Same-cycle `clear` + `wr_en`: clear applies, then the write wins at its address. Any accepted write or clear sets dirty.
- FSM states:
  - IDLE: if dirty or `refresh_req`, then row=0, clear dirty, go to CMD.
  - CMD: present `out_is_cmd`=1, `out_data` = 8'h80 | (row ? 8'h40 : 8'h00). On handshake, col=0, go to CHAR.
  - CHAR: present `out_is_cmd`=0, `out_data` = store[row*COLS+col]. On handshake, if col=COLS-1: if row=ROWS-1 go to DONE, else row++ and go to CMD. Otherwise col++.
  - DONE: `frame_done`=1 for one cycle, go to IDLE.
- Handshake = `out_valid` & `out_ready`. `out_data` and `out_is_cmd` are registered. They are held stable while `out_valid` & !`out_ready`.
- Character bytes are sampled from the store when loaded into the output register. A write during a frame either appears in that frame if not yet loaded, or sets dirty and triggers a following frame.
- `refresh_req` while busy is remembered as dirty.

## Timing
- IDLE with dirty/`refresh_req` at cycle N: `out_valid`=1 with the row-0 command at N+1.
- Handshake at cycle k: next item presented at k+1 with `out_valid` continuously high, so back-to-back transfers are possible.
- Full 2x16 frame with `out_ready` tied high: 34 transfer cycles, then `frame_done` on the following cycle. `busy` deasserts one cycle after `frame_done`.
- Async `reset` mid-frame: outputs drop immediately, store re-blanked, new frame after release.

## Configuration
- `LCD_BUF_ROW_DIRTY_EN` defined: per-row dirty bits. A frame sends only rows whose bit is set, each with its own command. `refresh_req` sets all bits. A frame with one dirty row is 17 transfers.
- Undefined: a single dirty flag; every frame sends all rows.

## Structure
- Shared package/header `lcd_pkg`: FSM state encoding, `LCD_CMD_SET_DDRAM` (8'h80), row base offsets (8'h00, 8'h40), default `BLANK_CHAR`.
- Sub-module `lcd_char_ram`: ROWS*COLS x 8 register store with synchronous write, single-cycle clear, combinational read. The sequencer FSM stays in the top module.

## Test plan
- Release reset, `out_ready`=1 → 34 items: 8'h80, 16×8'h20, 8'hC0, 16×8'h20; `frame_done` pulses once.
- Write 8'h41 to addr 0 and 8'h42 to addr 17 while idle → next frame has char[0]=8'h41 and row-1 char[1]=8'h42.
- Random `out_ready` stalls → `out_data`/`out_is_cmd` constant during every stall; no item lost or duplicated.
- Write addr 31 during a frame after its slot has been loaded → a second frame follows immediately and carries the new value.
- `clear` + `wr_en` (addr 5, 8'h58) in the same cycle → all blanks except char 5 = 8'h58; write to addr 40 (ROWS=2) ignored.
- With `LCD_BUF_ROW_DIRTY_EN`: write only row 1 → 17 transfers starting with 8'hC0; pull `reset` low mid-frame → `out_valid`=0 at once, full blank frame after release.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD text buffer: sequencer state encoding,
// HD44780 DDRAM command byte, row base offsets and the default blank glyph.
package lcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_CHAR = 2'd2,
    ST_DONE = 2'd3
  } lcd_state_e;

  localparam int         LCD_ADDR_W        = 5;
  localparam logic [7:0] LCD_CMD_SET_DDRAM = 8'h80;
  localparam logic [7:0] LCD_ROW0_BASE     = 8'h00;
  localparam logic [7:0] LCD_ROW1_BASE     = 8'h40;
  localparam logic [7:0] LCD_BLANK_CHAR    = 8'h20;

  // Set-DDRAM-address command that parks the cursor at column 0 of a row
  function automatic logic [7:0] ddram_cmd(input logic row_is_1);
    return LCD_CMD_SET_DDRAM | (row_is_1 ? LCD_ROW1_BASE : LCD_ROW0_BASE);
  endfunction

endpackage

// File: rtl/lcd_text_buffer_if.sv
// Bundle of the character-write port and the outgoing byte stream of the
// LCD text buffer. 'master' is the user/LCD-controller side, 'slave' is the
// buffer itself.
interface lcd_text_buffer_if;
  import lcd_pkg::*;

  logic                  wr_en;
  logic [LCD_ADDR_W-1:0] wr_addr;
  logic [7:0]            wr_data;
  logic                  clear;
  logic                  refresh_req;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_is_cmd;
  logic [7:0]            out_data;
  logic                  busy;
  logic                  frame_done;

  modport master (
    output wr_en, wr_addr, wr_data, clear, refresh_req, out_ready,
    input  out_valid, out_is_cmd, out_data, busy, frame_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, clear, refresh_req, out_ready,
    output out_valid, out_is_cmd, out_data, busy, frame_done
  );

endinterface

// File: rtl/lcd_char_ram.sv
// Character shadow store: DEPTH x 8 registers, synchronous write,
// single-cycle clear to BLANK_CHAR, combinational read. A write in the same
// cycle as a clear wins at its own address; out-of-range writes never match.
module lcd_char_ram
  import lcd_pkg::*;
#(
  parameter int         DEPTH      = 32,
  parameter logic [7:0] BLANK_CHAR = LCD_BLANK_CHAR
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [LCD_ADDR_W-1:0] wr_addr,
  input  logic [7:0]            wr_data,
  input  logic                  clear,
  input  logic [LCD_ADDR_W-1:0] rd_addr,
  output logic [7:0]            rd_data
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]       mem_q [DEPTH];
  logic [7:0]       mem_d [DEPTH];
  logic [DEPTH-1:0] wr_hit;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_hit
      assign wr_hit[gi] = wr_en && (wr_addr == LCD_ADDR_W'(gi));
    end
  endgenerate

  // Next contents: clear first, then the write overrides its own cell
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (clear)
        mem_d[i] = BLANK_CHAR;
      if (wr_hit[i])
        mem_d[i] = wr_data;
    end
  end

  // Store registers, blanked by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= BLANK_CHAR;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= mem_d[i];
    end
  end

  assign rd_data = (int'(rd_addr) < DEPTH) ? mem_q[rd_addr[IDX_W-1:0]] : BLANK_CHAR;

endmodule

// File: rtl/lcd_text_buffer.sv
// LCD text buffer: holds a ROWS x COLS character store and streams it to the
// LCD controller as, per row, one Set-DDRAM command then COLS characters.
// Output bytes are registered and held while the consumer stalls.
// Optional build macro LCD_BUF_ROW_DIRTY_EN: per-row dirty tracking, so a
// frame only carries the rows that changed (default: one flag, all rows).
module lcd_text_buffer
  import lcd_pkg::*;
#(
  parameter int         COLS       = 16,
  parameter int         ROWS       = 2,
  parameter logic [7:0] BLANK_CHAR = LCD_BLANK_CHAR
) (
  input  logic              clk,
  input  logic              reset,
  lcd_text_buffer_if.slave  bus
);

  localparam int DEPTH = ROWS * COLS;
  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
`ifdef LCD_BUF_ROW_DIRTY_EN
  localparam int DW    = ROWS;
`else
  localparam int DW    = 1;
`endif
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

  lcd_state_e            state_q, state_d;
  logic [RW-1:0]         row_q, row_d;
  logic [CW-1:0]         col_q, col_d;
  logic [ROWS-1:0]       rows_q, rows_d;
  logic [DW-1:0]         dirty_q, dirty_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_is_cmd_q, out_is_cmd_d;
  logic [7:0]            out_data_q, out_data_d;

  logic [RW-1:0]         rd_row;
  logic [CW-1:0]         rd_col;
  logic [LCD_ADDR_W-1:0] rd_addr;
  logic [7:0]            rd_data;
  logic                  wr_ok;
  logic                  handshake;
  logic                  start;
  logic [DW-1:0]         dirty_set;
  logic [ROWS-1:0]       start_rows;
  logic [RW-1:0]         first_row;
  logic [RW-1:0]         next_row;
  logic                  next_found;

  lcd_char_ram #(
    .DEPTH      (DEPTH),
    .BLANK_CHAR (BLANK_CHAR)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (bus.wr_en),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .clear   (bus.clear),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign wr_ok     = bus.wr_en && (int'(bus.wr_addr) < DEPTH);
  assign handshake = out_valid_q && bus.out_ready;
  assign start     = (state_q == ST_IDLE) && ((|dirty_q) || bus.refresh_req);
  assign rd_addr   = LCD_ADDR_W'(int'(rd_row) * COLS + int'(rd_col));

  // Dirty bits raised by store changes and by refresh requests seen mid-frame
  always_comb begin
    dirty_set = '0;
    if (bus.clear || (bus.refresh_req && (state_q != ST_IDLE)))
      dirty_set = '1;
`ifdef LCD_BUF_ROW_DIRTY_EN
    for (int r = 0; r < ROWS; r++) begin
      if (wr_ok && ((int'(bus.wr_addr) / COLS) == r))
        dirty_set[r] = 1'b1;
    end
`else
    if (wr_ok)
      dirty_set = '1;
`endif
    dirty_d = (start ? '0 : dirty_q) | dirty_set;
  end

  // Row selection: rows covered by a frame starting now, its first row, and
  // the next selected row after the one currently being sent
  always_comb begin
`ifdef LCD_BUF_ROW_DIRTY_EN
    start_rows = dirty_q | (bus.refresh_req ? {ROWS{1'b1}} : {ROWS{1'b0}});
`else
    start_rows = {ROWS{1'b1}};
`endif
    first_row  = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (start_rows[r])
        first_row = RW'(r);
    end
    next_row   = '0;
    next_found = 1'b0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (rows_q[r] && (r > int'(row_q))) begin
        next_row   = RW'(r);
        next_found = 1'b1;
      end
    end
  end

  // Sequencer next-state and output-register loading
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    rows_d       = rows_q;
    out_valid_d  = out_valid_q;
    out_is_cmd_d = out_is_cmd_q;
    out_data_d   = out_data_q;
    rd_row       = row_q;
    rd_col       = col_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          row_d        = first_row;
          rows_d       = start_rows;
          out_valid_d  = 1'b1;
          out_is_cmd_d = 1'b1;
          out_data_d   = ddram_cmd(first_row != '0);
          state_d      = ST_CMD;
        end
      end
      ST_CMD: begin
        if (handshake) begin
          col_d        = '0;
          rd_col       = '0;
          out_is_cmd_d = 1'b0;
          out_data_d   = rd_data;
          state_d      = ST_CHAR;
        end
      end
      ST_CHAR: begin
        if (handshake) begin
          if (col_q == COL_LAST) begin
            if (next_found) begin
              row_d        = next_row;
              out_is_cmd_d = 1'b1;
              out_data_d   = ddram_cmd(next_row != '0);
              state_d      = ST_CMD;
            end else begin
              out_valid_d  = 1'b0;
              out_is_cmd_d = 1'b0;
              out_data_d   = '0;
              state_d      = ST_DONE;
            end
          end else begin
            col_d      = col_q + 1'b1;
            rd_col     = col_q + 1'b1;
            out_data_d = rd_data;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; a frame follows reset via the dirty bits
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      row_q        <= '0;
      col_q        <= '0;
      rows_q       <= '0;
      dirty_q      <= '1;
      out_valid_q  <= 1'b0;
      out_is_cmd_q <= 1'b0;
      out_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      rows_q       <= rows_d;
      dirty_q      <= dirty_d;
      out_valid_q  <= out_valid_d;
      out_is_cmd_q <= out_is_cmd_d;
      out_data_q   <= out_data_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_is_cmd = out_is_cmd_q;
  assign bus.out_data   = out_data_q;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.frame_done = (state_q == ST_DONE);

endmodule
